// File: rtl/cpu6_bus_arbiter.sv
// Purpose : round-robin owner arbitration for the shared CPU6 system bus, with dead cycles between owners and hold-limit preemption.
// Latency : a request seen at a rising edge in IDLE is granted on that same edge; 1+TURN_CYCLES grant-free cycles separate two tenures.
// Backpress: req is level-sensitive and never dropped; masters simply keep req high until granted; lock inhibits preemption of the owner.
//
// Ports:
//   clock      system clock, all state changes on the rising edge
//   reset      asynchronous active-low reset (0 = reset)
//   req        per-master bus request, held for the whole tenure
//   lock       per-master preemption inhibit, only meaningful for the owner
//   grant      one-hot or all-zero bus grant
//   owner      index of the current owner, meaningful while busy=1
//   busy       1 whenever a grant is asserted
//   preempted  one-cycle pulse when a tenure ends by preemption
module cpu6_bus_arbiter #(
    parameter int NREQ        = 3,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] lock,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      owner,
    output logic            busy,
    output logic            preempted
);

    // Hold counter only needs to reach MAX_HOLD, where it saturates.
    localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
    localparam logic [3:0]    NREQ4    = 4'(NREQ);
    localparam logic [2:0]    LAST     = 3'(NREQ - 1);
    localparam logic [3:0]    TURN4    = 4'(TURN_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [3:0]      turn_q, turn_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [2:0]      owner_q, owner_d;
    logic            preempted_q, preempted_d;

    // Round-robin winner search
    logic [3:0]      cand;
    logic            found;
    logic [2:0]      win_idx;
    logic [NREQ-1:0] win_oh;

    // Owner status, derived through the one-hot grant so no variable indexing is needed
    logic       owner_req;
    logic       owner_lock;
    logic       others_req;
    logic       hold_full;
    logic       release_now;
    logic       preempt_now;
    logic [2:0] ptr_after;

    always_comb begin
        cand    = '0;
        found   = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        for (int i = 0; i < NREQ; i++) begin
            // cand = (ptr + i) mod NREQ, ptr is always < NREQ so one subtraction suffices
            cand = {1'b0, ptr_q} + 4'(i);
            if (cand >= NREQ4) begin
                cand = cand - NREQ4;
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (cand == 4'(j)) && req[j]) begin
                    found     = 1'b1;
                    win_idx   = 3'(j);
                    win_oh    = '0;
                    win_oh[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        owner_req   = |(req & grant_q);
        owner_lock  = |(lock & grant_q);
        others_req  = |(req & ~grant_q);
        hold_full   = (hold_q >= HOLD_MAX);
        release_now = !owner_req;
        preempt_now = (MAX_HOLD != 0) && hold_full && !owner_lock && others_req;
        ptr_after   = (owner_q == LAST) ? 3'd0 : owner_q + 3'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_q      <= '0;
            turn_q      <= '0;
            grant_q     <= '0;
            owner_q     <= '0;
            preempted_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            turn_q      <= turn_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            preempted_q <= preempted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        turn_d      = turn_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        preempted_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = win_oh;
                    owner_d = win_idx;
                    hold_d  = HOLD_ONE;
                    state_d = OWN;
                end
            end

            OWN: begin
                if (release_now || preempt_now) begin
                    grant_d     = '0;
                    ptr_d       = ptr_after;
                    // A voluntary release on the same edge is not reported as preemption
                    preempted_d = preempt_now && !release_now;
                    if (TURN_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = TURN;
                        turn_d  = TURN4;
                    end
                end else if (!hold_full) begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end

            TURN: begin
                if (turn_q <= 4'd1) begin
                    turn_d  = 4'd0;
                    state_d = IDLE;
                end else begin
                    turn_d = turn_q - 4'd1;
                end
            end

            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign grant     = grant_q;
    assign owner     = owner_q;
    assign busy      = |grant_q;
    assign preempted = preempted_q;

    a_grant_onehot: assert property (@(posedge clock) disable iff (!reset)
        $onehot0(grant));

    a_busy_matches: assert property (@(posedge clock) disable iff (!reset)
        busy == (|grant));

    a_owner_stable: assert property (@(posedge clock) disable iff (!reset)
        (busy && $past(busy)) |-> (owner == $past(owner)));

endmodule

// File: tb/tb_cpu6_bus_arbiter.sv
module tb_cpu6_bus_arbiter;

    localparam int NREQ = 3;
    localparam int TURN = 1;
    localparam int MAXH = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NREQ-1:0] req   = '0;
    logic [NREQ-1:0] lock  = '0;
    logic [NREQ-1:0] grant;
    logic [2:0]      owner;
    logic            busy;
    logic            preempted;

    int checks   = 0;
    int failures = 0;

    cpu6_bus_arbiter #(
        .NREQ       (NREQ),
        .TURN_CYCLES(TURN),
        .MAX_HOLD   (MAXH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .lock     (lock),
        .grant    (grant),
        .owner    (owner),
        .busy     (busy),
        .preempted(preempted)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks who owns the bus, when the tenure started
    // (in edges), and the earliest edge a new grant may be issued.
    bit m_busy;
    int m_owner, m_gedge, m_ptr, m_next_ok, edge_no;
    bit m_pre;
    int k, w;
    bit rel, pre, oth, found;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_pre = 0;
            m_next_ok = 0; edge_no = 0; m_gedge = 0;
        end else begin
            edge_no = edge_no + 1;
            m_pre = 0;
            if (m_busy) begin
                k   = edge_no - m_gedge;       // hold value seen at this edge, before saturation
                rel = (req[m_owner] == 1'b0);
                oth = 0;
                for (int i = 0; i < NREQ; i++) if (i != m_owner && req[i]) oth = 1;
                pre = (MAXH != 0) && (k >= MAXH) && !lock[m_owner] && oth;
                if (rel || pre) begin
                    m_busy    = 0;
                    m_pre     = pre && !rel;
                    m_ptr     = (m_owner + 1) % NREQ;
                    m_next_ok = edge_no + 1 + TURN;
                end
            end else if (edge_no >= m_next_ok) begin
                found = 0;
                for (int i = 0; i < NREQ; i++) begin
                    w = (m_ptr + i) % NREQ;
                    if (!found && req[w]) begin
                        found   = 1;
                        m_busy  = 1;
                        m_owner = w;
                        m_gedge = edge_no;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("grant", 32'(grant), m_busy ? (32'd1 << m_owner) : 32'd0);
            chk("busy", 32'(busy), 32'(m_busy));
            chk("preempted", 32'(preempted), 32'(m_pre));
            if (m_busy) chk("owner", 32'(owner), 32'(m_owner));
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        repeat (3) @(negedge clock);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_preempted", 32'(preempted), 0);
        reset = 1'b1;
    endtask

    // Counts grant-free negedges (including the current one) until a grant appears.
    task automatic wait_grant(output int zeros);
        zeros = 0;
        for (int n = 0; n < 200; n++) begin
            if (grant != '0) break;
            zeros++;
            @(negedge clock);
        end
        chk("grant_seen", 32'(grant != '0), 1);
    endtask

    int z, cnt, bad;
    logic [NREQ-1:0] rr_exp [4];

    initial begin
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

        // Reset then single request, release, re-request across the turnaround
        do_reset();
        req = 3'b001;
        @(negedge clock);
        chk("s1_grant", 32'(grant), 3'b001);
        chk("s1_busy", 32'(busy), 1);
        chk("s1_owner", 32'(owner), 0);
        req = 3'b000;
        @(negedge clock);
        chk("s1_drop", 32'(grant), 0);
        req = 3'b001;
        wait_grant(z);
        chk("s1_gap", z, 2);
        chk("s1_regrant", 32'(grant), 3'b001);
        req = 3'b000;
        @(negedge clock);

        // Round robin with all masters requesting
        do_reset();
        req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            wait_grant(z);
            chk("rr_grant", 32'(grant), 32'(rr_exp[t]));
            if (t > 0) chk("rr_gap", z, 2);
            repeat (3) @(negedge clock);
            req = req & ~grant;
            @(negedge clock);
            req = 3'b111;
        end
        req = 3'b000;
        @(negedge clock);

        // Preemption at the hold limit
        do_reset();
        req = 3'b001;
        wait_grant(z);
        repeat (2) @(negedge clock);
        req = 3'b011;
        cnt = 3;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (grant == 3'b001) cnt++;
            else break;
        end
        chk("pre_tenure", cnt, 8);
        chk("pre_grant_fall", 32'(grant), 0);
        chk("pre_pulse", 32'(preempted), 1);
        @(negedge clock);
        chk("pre_pulse_end", 32'(preempted), 0);
        wait_grant(z);
        chk("pre_gap", z + 1, 2);
        chk("pre_next", 32'(grant), 3'b010);
        req = 3'b000;
        @(negedge clock);

        // Lock inhibits preemption until it is dropped
        do_reset();
        lock = 3'b001;
        req  = 3'b001;
        wait_grant(z);
        repeat (2) @(negedge clock);
        req = 3'b011;
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (grant !== 3'b001) bad++;
        end
        chk("lock_hold_errs", bad, 0);
        lock = 3'b000;
        @(negedge clock);
        chk("lock_rel_grant", 32'(grant), 0);
        chk("lock_rel_pulse", 32'(preempted), 1);
        wait_grant(z);
        chk("lock_next", 32'(grant), 3'b010);
        req = 3'b000;
        @(negedge clock);

        // Release coincides with the hold limit: release wins, no pulse
        do_reset();
        req = 3'b001;
        wait_grant(z);
        repeat (2) @(negedge clock);
        req = 3'b101;
        repeat (5) @(negedge clock);
        req = 3'b100;
        @(negedge clock);
        chk("coin_grant", 32'(grant), 0);
        chk("coin_pulse", 32'(preempted), 0);
        wait_grant(z);
        chk("coin_next", 32'(grant), 3'b100);
        req = 3'b000;
        @(negedge clock);

        // Asynchronous reset in the middle of a tenure
        do_reset();
        req = 3'b010;
        wait_grant(z);
        chk("ar_grant", 32'(grant), 3'b010);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_grant_drop", 32'(grant), 0);
        chk("ar_busy_drop", 32'(busy), 0);
        @(negedge clock);
        req   = 3'b110;
        reset = 1'b1;
        wait_grant(z);
        chk("ar_after", 32'(grant), 3'b010);
        req = 3'b000;
        @(negedge clock);

        // Random traffic against the model
        do_reset();
        repeat (3000) begin
            @(negedge clock);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 15) == 0) lock[i] = ~lock[i];
            end
        end
        req  = '0;
        lock = '0;
        repeat (4) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu6_bus_arbiter.md
Name: cpu6_bus_arbiter

Overview:
- Shares the CPU6 system bus (addressBus/dataBus, memory and device strobes) between up to NREQ bus masters.
- Default masters: 0 = CPU6 core, 1 = DMA channel, 2 = front-panel/boot loader.
- Issues one-hot grants using round-robin priority.
- Enforces dead (turnaround) cycles between owners so that bus drivers never overlap.
- Optionally preempts an owner that exceeds a hold limit, unless that owner asserts lock.

Parameters:
- NREQ, 3, number of requesters (2..8).
- TURN_CYCLES, 1, extra grant-free cycles inserted after every tenure (0..15).
- MAX_HOLD, 64, tenure length in cycles after which an unlocked owner is preempted if another request is pending; 0 disables preemption.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- req  input  NREQ  per-master bus request; level-sensitive; held high for the whole tenure.
- lock  input  NREQ  per-master preemption inhibit; only sampled for the current owner.
- grant  output  NREQ  one-hot (or all-zero) bus grant.
- owner  output  3  index of the current owner; valid only while busy=1.
- busy  output  1  1 when any grant is asserted.
- preempted  output  1  one-cycle pulse when a tenure ends by preemption.

Behaviour:
- Reset (reset=0, asynchronous):
  - grant=0, owner=0, busy=0, preempted=0.
  - state=IDLE, priority pointer ptr=0, hold counter=0, turnaround counter=0.
  - Asserting reset mid-tenure drops grant immediately, without waiting for a clock edge.
- States: IDLE, OWN, TURN.
- IDLE:
  - If any req bit is 1 at a rising edge, winner w = first set bit scanning ptr, ptr+1, ... modulo NREQ.
  - On that same edge: grant[w]=1, owner=w, busy=1, hold=1, state→OWN.
  - Latency: req rising before edge k gives grant visible after edge k.
  - If no request, remain in IDLE.
- OWN, evaluated each edge:
  - Release: req[owner]=0.
  - Preempt: MAX_HOLD≠0, hold≥MAX_HOLD, lock[owner]=0, and some req[i]=1 for i≠owner.
  - If release or preempt: grant=0, busy=0, ptr=(owner+1) mod NREQ.
    - preempted=1 for one cycle only if it was preempt and not release; release wins when both are true.
    - state→TURN with the turnaround counter loaded with TURN_CYCLES, or →IDLE if TURN_CYCLES=0.
  - Otherwise hold = min(hold+1, MAX_HOLD) (saturating) and the grant is held.
  - lock=1 holds the bus indefinitely while req[owner]=1; lock never forces a grant.
- TURN:
  - Count down once per cycle; grant stays 0.
  - When the counter reaches 1 at an edge, state→IDLE.
  - Requests arriving during TURN are not lost (level-sensitive); they are arbitrated in IDLE.
- Grant-free cycles between two tenures: exactly 1+TURN_CYCLES cycles from the grant falling to the next grant rising (IDLE arbitration cycle included).
- A preempted owner that keeps req=1 re-competes normally; it has lowest priority because ptr has moved past it.
- Bits of req/lock at index ≥NREQ do not exist.
- Invariants (also assertions):
  - grant is zero or one-hot.
  - busy == |grant.
  - owner is constant while busy=1.

Test Plan:
- Reset then single request: reset low 3 cycles, release; req=3'b001 → grant=3'b001 one edge later, busy=1, owner=0; drop req → grant=0 next edge; with TURN_CYCLES=1 a re-request is regranted after exactly 2 grant-free cycles.
- Round robin: req=3'b111 held constantly, each master drops req after 4 cycles of tenure then re-raises → grant sequence 001, 010, 100, 001, each separated by 2 zero-grant cycles.
- Preemption: MAX_HOLD=8, master 0 holds req, master 1 raises req at tenure cycle 3 → master 0's grant falls at the edge where hold=8, preempted pulses 1 cycle, grant=3'b010 after the turnaround.
- Lock inhibits preemption: same as the previous scenario with lock[0]=1 → no preemption for 100 cycles; lock[0]→0 → preemption at the next edge, preempted=1.
- Release and preempt coincide: master 0 drops req on the same edge hold reaches MAX_HOLD with master 2 pending → grant falls, preempted stays 0, master 2 granted next.
- Asynchronous reset mid-tenure: grant=3'b010, pull reset low between edges → grant=0, busy=0 immediately; after release with req=3'b110 → master 1 granted (ptr reset to 0).
